keypad_scanner: RTL and testbench

Scans a 4×4 matrix keypad, debounces the pressed key, and produces a 4-bit key code plus a held decimal digit.
- Sits directly upstream of the 7-segment decoder: `o_digit` feeds the decoder's 4-bit number input.
- Non-digit keys are reported on `o_key_code` but never reach the display.

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/sync_2ff.sv | 34 +++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_e      : scanner FSM states
//   - KEY_MAP      : 16-entry key code table indexed by {row, col}
//   - KEY_STAR/HASH: codes for the two non-alphanumeric keys
//   - is_one_low() : true when exactly one bit of an active-low vector is low
//   - row_index()  : row number of a one-hot-low row pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Element [i] holds the code for index i = {row, col}; listed from
  // index 15 (row 3, col 3) down to index 0 (row 0, col 0).
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,   // row 3: * 0 # D
    4'hC, 4'h9,     4'h8, 4'h7,       // row 2: 7 8 9 C
    4'hB, 4'h6,     4'h5, 4'h4,       // row 1: 4 5 6 B
    4'hA, 4'h3,     4'h2, 4'h1        // row 0: 1 2 3 A
  };

  function automatic logic is_one_low(input logic [3:0] v);
    logic [3:0] inv;
    inv = ~v;
    // Non-zero and a power of two: exactly one row pulled low.
    return (inv != 4'b0000) && ((inv & (inv - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a multi-bit level signal whose bits are
// individually asynchronous to i_clk. Both stages reset to all ones,
// which is the idle (no key) level of the active-low keypad rows.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output, two cycles of latency
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// the single pressed key on press and on release, and reports it.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_row          : keypad rows, active-low, asynchronous
//   o_col          : column drive, active-low, exactly one bit low
//   o_key_code     : code of the last accepted key
//   o_key_valid    : one-cycle pulse when a key is accepted
//   o_key_held     : high from acceptance until the release is debounced
//   o_digit        : last accepted decimal key (0-9)
//   o_digit_valid  : sticky flag, set by the first accepted decimal key
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held,
  output logic [3:0] o_digit,
  output logic       o_digit_valid
);
  import keypad_pkg::*;

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0] row_s;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_row),
    .o_q     (row_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_drive_q, col_drive_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic [3:0]       lookup_code;

  // The column stays frozen from latch until release, so col_q together
  // with the latched row pattern identifies the key.
  assign lookup_code = KEY_MAP[{row_index(row_pat_q), col_q}];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_SCAN;
      dwell_q       <= '0;
      deb_q         <= '0;
      col_q         <= 2'd0;
      col_drive_q   <= 4'b1110;
      row_pat_q     <= 4'hF;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      digit_q       <= 4'h0;
      digit_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      deb_q         <= deb_d;
      col_q         <= col_d;
      col_drive_q   <= col_drive_d;
      row_pat_q     <= row_pat_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    deb_d         = deb_q;
    col_d         = col_q;
    row_pat_d     = row_pat_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          // Rows are only trusted at the end of the dwell, once the
          // column drive has propagated through the synchronizer.
          if (is_one_low(row_s)) begin
            row_pat_d = row_s;
            deb_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + CNT_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (row_s != row_pat_q) begin
          dwell_d = '0;
          state_d = ST_SCAN;
        end else if (deb_q == DEB_LAST) begin
          state_d     = ST_PRESSED;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          key_code_d  = lookup_code;
          if (lookup_code <= 4'd9) begin
            digit_d       = lookup_code;
            digit_valid_d = 1'b1;
          end
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end

      ST_PRESSED: begin
        if (row_s != row_pat_q) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_s != 4'hF) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          key_held_d = 1'b0;
          col_d      = col_q + 2'd1;
          dwell_d    = '0;
          state_d    = ST_SCAN;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_drive_d = ~(4'b0001 << col_d);
  end

  assign o_col         = col_drive_q;
  assign o_key_code    = key_code_q;
  assign o_key_valid   = key_valid_q;
  assign o_key_held    = key_held_q;
  assign o_digit       = digit_q;
  assign o_digit_valid = digit_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner
// Keypad model closes switches in a 16-bit array (index row*4+col); the
// reference model predicts accepted key codes and the displayed digit.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] o_col, o_key_code, o_digit;
  logic       o_key_valid, o_key_held, o_digit_valid;

  logic [15:0] closed = 16'h0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_row         (row),
    .o_col         (o_col),
    .o_key_code    (o_key_code),
    .o_key_valid   (o_key_valid),
    .o_key_held    (o_key_held),
    .o_digit       (o_digit),
    .o_digit_valid (o_digit_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- keypad matrix model ----------------
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (closed[r*4+c] && !o_col[c]) row[r] = 1'b0;
  end

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Printed key layout: digits count 1..9 across rows 0-2, letters down col 3.
  function automatic logic [3:0] model_code(input int r, input int c);
    if (c == 3) return 4'(10 + r);
    if (r < 3)  return 4'(r * 3 + c + 1);
    if (c == 0) return 4'hE;
    if (c == 1) return 4'h0;
    return 4'hF;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [3:0] exp_q[$];
  logic [3:0] m_code    = 4'h0;
  logic [3:0] m_digit   = 4'h0;
  logic       m_dvalid  = 1'b0;
  int         valid_cnt = 0;

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_code   = 4'h0;
      m_digit  = 4'h0;
      m_dvalid = 1'b0;
      check("reset_outputs",
            {o_col, o_key_code, o_key_valid, o_key_held, o_digit, o_digit_valid},
            {4'b1110, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0});
    end else begin
      if (o_key_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(o_key_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          m_code = e;
          if (e <= 4'd9) begin
            m_digit  = e;
            m_dvalid = 1'b1;
          end
        end
      end
      check("key_code",    o_key_code, m_code);
      check("digit",       o_digit, m_digit);
      check("digit_valid", o_digit_valid, m_dvalid);
      check("col_one_low", $countones(~o_col), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press_wait(input int r, input int c, input string name);
    int start;
    start = valid_cnt;
    exp_q.push_back(model_code(r, c));
    closed[r*4+c] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_cnt != start) break;
    end
    check({name, "_accepted"}, 32'(valid_cnt - start), 32'd1);
    check({name, "_held"}, 32'(o_key_held), 32'd1);
  endtask

  task automatic release_wait(input int r, input int c, input string name);
    closed[r*4+c] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!o_key_held) break;
    end
    check({name, "_released"}, 32'(o_key_held), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_col;
    int start;
    int k, r, c, j;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. idle rotation
    check("t1_col_start", o_col, 4'b1110);
    for (int e = 1; e <= 64; e++) begin
      tick();
      exp_col = ~(4'b0001 << ((e / SCAN_DIV) % 4));
      check("t1_col", o_col, exp_col);
      check("t1_quiet", {o_key_valid, o_key_held}, 2'b00);
    end

    // 2. press 5 (row1/col1) then release
    start = valid_cnt;
    press_wait(1, 1, "t2");
    check("t2_code",   o_key_code, 4'h5);
    check("t2_digit",  o_digit, 4'h5);
    check("t2_dvalid", 32'(o_digit_valid), 32'd1);
    for (int i = 0; i < 80; i++) begin
      tick();
      check("t2_col_frozen", o_col, 4'b1101);
      check("t2_held", 32'(o_key_held), 32'd1);
    end
    check("t2_one_pulse", 32'(valid_cnt - start), 32'd1);
    closed[1*4+1] = 1'b0;
    // 2 synchronizer cycles, 1 to see the change, then DEB release cycles.
    for (int i = 1; i <= DEB + 3; i++) begin
      tick();
      if (i == DEB + 2) check("t2_held_before_fall", 32'(o_key_held), 32'd1);
      if (i == DEB + 3) begin
        check("t2_held_fall", 32'(o_key_held), 32'd0);
        check("t2_resume_col2", o_col, 4'b1011);
      end
    end

    // 3. bounce 7 (row2/col0) for 5 cycles
    for (int i = 0; i < 20 && o_col != 4'b1110; i++) tick();
    check("t3_col0_reached", o_col, 4'b1110);
    start = valid_cnt;
    closed[2*4+0] = 1'b1;
    idle(5);
    closed[2*4+0] = 1'b0;
    idle(40);
    check("t3_no_pulse", 32'(valid_cnt - start), 32'd0);
    check("t3_code_kept", o_key_code, 4'h5);

    // 4. press 7, release, press A
    press_wait(2, 0, "t4_7");
    check("t4_code7",  o_key_code, 4'h7);
    check("t4_digit7", o_digit, 4'h7);
    idle(20);
    release_wait(2, 0, "t4_7");
    idle(10);
    press_wait(0, 3, "t4_A");
    check("t4_codeA",  o_key_code, 4'hA);
    check("t4_digit_kept", o_digit, 4'h7);
    idle(10);
    release_wait(0, 3, "t4_A");
    idle(10);

    // 5. ghost pair 1+7 in column 0, then #
    start = valid_cnt;
    closed[0] = 1'b1;
    closed[8] = 1'b1;
    idle(60);
    check("t5_pair_ignored", 32'(valid_cnt - start), 32'd0);
    closed[0] = 1'b0;
    closed[8] = 1'b0;
    idle(10);
    press_wait(3, 2, "t5_hash");
    check("t5_code_hash", o_key_code, 4'hF);
    check("t5_digit_kept", o_digit, 4'h7);
    idle(10);
    release_wait(3, 2, "t5_hash");
    idle(10);

    // 6. hold 0, reset during PRESSED, release reset with key held
    press_wait(3, 1, "t6_first");
    check("t6_code0", o_key_code, 4'h0);
    idle(5);
    rst_n = 1'b0;
    #1;
    check("t6_async_col",  o_col, 4'b1110);
    check("t6_async_held", 32'(o_key_held), 32'd0);
    check("t6_async_dv",   32'(o_digit_valid), 32'd0);
    idle(5);
    rst_n = 1'b1;
    check("t6_restart_col0", o_col, 4'b1110);
    start = valid_cnt;
    press_wait(3, 1, "t6_again");
    check("t6_code_again", o_key_code, 4'h0);
    check("t6_dv_again", 32'(o_digit_valid), 32'd1);
    idle(40);
    check("t6_no_repeat", 32'(valid_cnt - start), 32'd1);
    release_wait(3, 1, "t6");
    idle(10);

    // Randomized presses, with stray bounces and ignored second keys.
    for (int it = 0; it < 16; it++) begin
      k = int'($urandom_range(0, 15));
      r = k / 4;
      c = k % 4;
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(0, 15));
        start = valid_cnt;
        closed[j] = 1'b1;
        idle(int'($urandom_range(1, 5)));
        closed[j] = 1'b0;
        idle(30);
        check("rnd_bounce_no_pulse", 32'(valid_cnt - start), 32'd0);
      end
      start = valid_cnt;
      press_wait(r, c, "rnd");
      check("rnd_code", o_key_code, model_code(r, c));
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(0, 3)) * 4 + ((c + 1 + int'($urandom_range(0, 2))) % 4);
        closed[j] = 1'b1;
        idle(int'($urandom_range(5, 20)));
        closed[j] = 1'b0;
      end
      idle(int'($urandom_range(10, 40)));
      check("rnd_single_pulse", 32'(valid_cnt - start), 32'd1);
      release_wait(r, c, "rnd");
      idle(int'($urandom_range(5, 20)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
